// File: rtl/fb_scanner_pkg.sv
// Shared types and constants for the frame-buffer scanner.
// The 2 bpp layout packs four pixels per byte, MSB first.
package fb_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int PIX_PER_BYTE = 4;
    localparam int BPP          = 2;

endpackage

// File: rtl/fb_scanner_if.sv
// Pixel stream from the scanner to the display sink.
// The stream uses a valid/ready handshake with start-of-row and end-of-frame markers.
interface fb_scanner_if;
    import fb_scanner_pkg::*;

    logic           pix_valid;
    logic           pix_ready;
    logic [BPP-1:0] pix_data;
    logic           pix_sol;
    logic           pix_eof;

    modport master (output pix_valid, pix_data, pix_sol, pix_eof, input pix_ready);
    modport slave  (input pix_valid, pix_data, pix_sol, pix_eof, output pix_ready);

endinterface

// File: rtl/fb_scanner_byte_fifo2.sv
// Two-entry byte FIFO between the ROM read port and the pixel serializer.
// Writes into a full FIFO are prevented upstream by the read-issue rule.
module byte_fifo2
    import fb_scanner_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic [1:0] occ,
    output logic       empty
);

    logic [1:0][7:0] slots;
    logic            wr_ptr;
    logic            rd_ptr;

    assign rd_data = slots[rd_ptr];
    assign empty   = (occ == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (wr_en) begin
                slots[wr_ptr] <= wr_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (rd_en) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/fb_scanner.sv
// Scans one frame out of a synchronous ROM and streams it as 2 bpp pixels.
// Reads run ahead of the serializer by at most two bytes: FIFO occupancy plus in-flight reads.
module fb_scanner
    import fb_scanner_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR     = 12'h000,
    parameter int          BYTES_PER_ROW = 64,
    parameter int          ROWS          = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [11:0]  mem_addr,
    input  logic [7:0]   mem_dout,
    fb_scanner_if.master pix,
    output logic         busy,
    output logic         done
);

    localparam int TOTAL_BYTES = BYTES_PER_ROW * ROWS;
    localparam int TOTAL_PIX   = TOTAL_BYTES * PIX_PER_BYTE;
    localparam int ROW_PIX     = BYTES_PER_ROW * PIX_PER_BYTE;
    localparam int PIX_W       = $clog2(TOTAL_PIX);
    localparam int COL_W       = (ROW_PIX > 1) ? $clog2(ROW_PIX) : 1;
    localparam int RD_W        = $clog2(TOTAL_BYTES + 1);

    state_t           state;
    state_t           state_nxt;
    logic [RD_W-1:0]  rd_left;
    logic             in_flight;
    logic [PIX_W-1:0] pix_cnt;
    logic [COL_W-1:0] col_cnt;
    logic             rd_issue;
    logic [1:0]       occ;
    logic [1:0]       pending;
    logic             fifo_empty;
    logic             fifo_rd;
    logic [7:0]       fifo_head;
    logic [7:0]       byte_shift;
    logic [1:0]       sub;
    logic             is_eof;
    logic             xfer;

    // A read returns one cycle after issue; the in-flight flag marks that return slot.
    byte_fifo2 u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (in_flight),
        .wr_data (mem_dout),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .occ     (occ),
        .empty   (fifo_empty)
    );

    assign pending    = occ + {1'b0, in_flight};
    assign sub        = pix_cnt[1:0];
    assign byte_shift = fifo_head << {sub, 1'b0};
    assign is_eof     = (pix_cnt == PIX_W'(TOTAL_PIX - 1));
    assign xfer       = !fifo_empty && pix.pix_ready;
    assign fifo_rd    = xfer && (sub == 2'd3);

    assign pix.pix_valid = !fifo_empty;
    assign pix.pix_data  = fifo_empty ? '0 : byte_shift[7:6];
    assign pix.pix_sol   = !fifo_empty && (col_cnt == '0);
    assign pix.pix_eof   = !fifo_empty && is_eof;
    assign busy          = (state != IDLE);

    always_comb begin
        state_nxt = state;
        rd_issue  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                rd_issue = (pending < 2'd2);
                if (rd_issue && rd_left == RD_W'(1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (xfer && is_eof) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_addr  <= BASE_ADDR;
            rd_left   <= '0;
            in_flight <= 1'b0;
            pix_cnt   <= '0;
            col_cnt   <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_flight <= rd_issue;
            done      <= xfer && is_eof;
            if (state == IDLE && start) begin
                mem_addr <= BASE_ADDR;
                rd_left  <= RD_W'(TOTAL_BYTES);
                pix_cnt  <= '0;
                col_cnt  <= '0;
            end else if (rd_issue) begin
                mem_addr <= mem_addr + 12'd1;
                rd_left  <= rd_left - RD_W'(1);
            end
            if (xfer) begin
                pix_cnt <= is_eof ? '0 : pix_cnt + PIX_W'(1);
                col_cnt <= (col_cnt == COL_W'(ROW_PIX - 1)) ? '0 : col_cnt + COL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fb_scanner.sv
// Scoreboard bench for fb_scanner: each start queues a whole frame of expected pixels,
// and a negedge monitor pops and compares on every handshake.
module tb_fb_scanner;
    localparam int NPIX = 8192;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] mem_addr;
    logic [7:0]  mem_dout = 8'h00;
    logic        busy;
    logic        done;
    logic [7:0]  mem [4096];

    fb_scanner_if pif();

    fb_scanner dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .pix      (pif),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mem_dout <= mem[mem_addr];

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];
    logic [1:0] cap [NPIX];
    int pix_idx = 0;
    int sol_cnt = 0;
    int cyc = 0;
    int first_cyc = 0;
    bit consec = 1'b1;
    bit prev_stall = 1'b0;
    bit prev_eof = 1'b0;
    logic [3:0] prev_word = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame model: pixel k comes from byte k/4, two bits at a time from the top.
    function automatic logic [3:0] model_pix(input int k);
        logic [7:0] b;
        int sh;
        b  = mem[k / 4];
        sh = 6 - 2 * (k % 4);
        return {2'((b >> sh) & 8'h03), (k % 256) == 0, k == NPIX - 1};
    endfunction

    task automatic issue_start();
        for (int k = 0; k < NPIX; k++) exp_q.push_back(model_pix(k));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic wait_pix(input int idx);
        for (int n = 0; n < 40000; n++) begin
            if (pix_idx >= idx) return;
            @(posedge clk);
            #1;
        end
        chk("pix_idx_timeout", pix_idx, idx);
    endtask

    always @(negedge clk) begin
        logic [3:0] w;
        logic [3:0] e;
        cyc++;
        w = {pif.pix_data, pif.pix_sol, pif.pix_eof};
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_eof   = 1'b0;
            pix_idx    = 0;
            sol_cnt    = 0;
        end else begin
            if (done || prev_eof) begin
                chk("done_pulse", done, prev_eof);
                if (prev_eof) chk("busy_at_done", busy, 0);
            end
            if (prev_stall) chk("stall_hold", {pif.pix_valid, w}, {1'b1, prev_word});
            prev_eof = 1'b0;
            if (pif.pix_valid && pif.pix_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pixel", pix_idx, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel_word", w, e);
                end
                if (pix_idx == 0) first_cyc = cyc;
                if (pix_idx < NPIX) cap[pix_idx] = pif.pix_data;
                if (pif.pix_sol) sol_cnt++;
                pix_idx++;
                if (pif.pix_eof) begin
                    chk("frame_len", pix_idx, NPIX);
                    chk("sol_count", sol_cnt, 32);
                    if (consec) chk("frame_cycles", cyc - first_cyc, NPIX - 1);
                    prev_eof = 1'b1;
                    pix_idx  = 0;
                    sol_cnt  = 0;
                end
            end
            prev_stall = pif.pix_valid && !pif.pix_ready;
            prev_word  = w;
        end
    end

    initial begin
        logic [1:0] head_exp [8];
        logic [1:0] tail_exp [8];
        head_exp = '{2'd3, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
        tail_exp = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0};
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hC8; mem[1] = 8'h84; mem[2046] = 8'h48; mem[2047] = 8'h8C;
        pif.pix_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_valid", pif.pix_valid, 0);
        chk("rst_word", {pif.pix_data, pif.pix_sol, pif.pix_eof}, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_addr", mem_addr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Frame 1: full rate, latency and fixed-pattern checks
        issue_start();
        @(negedge clk); chk("lat_cycle1", pif.pix_valid, 0);
        @(negedge clk); chk("lat_cycle2", pif.pix_valid, 0);
        @(negedge clk); chk("lat_cycle3", pif.pix_valid, 1);
        wait_done(NPIX + 20);
        for (int i = 0; i < 8; i++) chk("head_pix", cap[i], head_exp[i]);
        for (int i = 0; i < 8; i++) chk("tail_pix", cap[NPIX - 8 + i], tail_exp[i]);

        // Frame 2: started on the done cycle; a second start mid-frame is ignored
        issue_start();
        wait_pix(100);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_in_frame", busy, 1);
        wait_done(NPIX + 20);

        // Frame 3: 10-cycle stall mid-byte, then random backpressure
        issue_start();
        consec = 1'b0;
        wait_pix(1026);
        pif.pix_ready = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        for (int n = 0; n < 40000; n++) begin
            if (done) break;
            pif.pix_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        chk("stall_frame_done", done, 1);
        pif.pix_ready = 1'b1;
        consec = 1'b1;
        @(negedge clk);

        // Frame 4: aborted by reset at pixel 3000, then a clean frame
        issue_start();
        wait_pix(3000);
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            chk("abort_valid", pif.pix_valid, 0);
            chk("abort_word", {pif.pix_data, pif.pix_sol, pif.pix_eof}, 0);
            chk("abort_busy_done", {busy, done}, 0);
            chk("abort_addr", mem_addr, 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        issue_start();
        wait_done(NPIX + 20);
        chk("restart_first_pix", cap[0], 3);

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
